// File: rtl/recv_all_pkg.sv
// recv_all_pkg: definitions shared by the inter-board receive path and the
// matching send path.
//   - message field widths and the link word width / word count
//   - word-index constants naming which field each word carries
//   - recv_single handshake state encodings
//   - next_word_idx(): word index advance with wrap after the last word
package recv_all_pkg;

    localparam int unsigned WORD_W     = 6;
    localparam int unsigned WORD_CNT   = 6;

    localparam int unsigned MSG_TYPE_W = 4;
    localparam int unsigned BLOCK_X_W  = 5;
    localparam int unsigned BLOCK_Y_W  = 3;
    localparam int unsigned CARD_W     = 6;
    localparam int unsigned SEL_LEN_W  = 3;
    localparam int unsigned MOVE_DIR_W = 1;

    localparam logic [2:0] IDX_MSG_TYPE = 3'd0;
    localparam logic [2:0] IDX_BLOCK_X  = 3'd1;
    localparam logic [2:0] IDX_BLOCK_Y  = 3'd2;
    localparam logic [2:0] IDX_CARD     = 3'd3;
    localparam logic [2:0] IDX_SEL_LEN  = 3'd4;
    localparam logic [2:0] IDX_MOVE_DIR = 3'd5;

    typedef enum logic [1:0] {
        WAIT_REQ_UP   = 2'd0,
        WAIT_REQ_DOWN = 2'd1,
        FIN           = 2'd2
    } rs_state_e;

    function automatic logic [2:0] next_word_idx(input logic [2:0] idx);
        if (idx == 3'(WORD_CNT - 1)) begin
            return IDX_MSG_TYPE;
        end else begin
            return idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/recv_all_single.sv
// recv_single: receives one 6-bit word over a four-phase Request/Ack link.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_in         asynchronous request from the peer board
//   data_in        peer data word, stable while req_in is high
//   ack            acknowledge to the peer (high in WAIT_REQ_DOWN)
//   word           word latched when the synchronized request is seen high
//   word_done      one-cycle pulse in FIN: word is complete
module recv_single
    import recv_all_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              ack,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic      req_meta_r;
    logic      req_sync_r;
    rs_state_e state_r;
    rs_state_e state_nxt_s;
    logic      latch_s;

    // Two-flop synchronizer on the asynchronous request line.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_meta_r <= 1'b0;
            req_sync_r <= 1'b0;
        end else begin
            req_meta_r <= req_in;
            req_sync_r <= req_meta_r;
        end
    end

    // Handshake next-state decision and word-latch enable.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        case (state_r)
            WAIT_REQ_UP: begin
                if (req_sync_r) begin
                    state_nxt_s = WAIT_REQ_DOWN;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = WAIT_REQ_UP;
                end
            end
            WAIT_REQ_DOWN: begin
                if (!req_sync_r) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = WAIT_REQ_DOWN;
                end
            end
            FIN: begin
                state_nxt_s = WAIT_REQ_UP;
            end
            default: begin
                state_nxt_s = WAIT_REQ_UP;
            end
        endcase
    end

    // State register; ack and word_done are registered decodes of the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= WAIT_REQ_UP;
            ack       <= 1'b0;
            word_done <= 1'b0;
            word      <= {WORD_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            ack       <= (state_nxt_s == WAIT_REQ_DOWN);
            word_done <= (state_nxt_s == FIN);
            if (latch_s) begin
                word <= data_in;
            end
        end
    end

endmodule

// File: rtl/recv_all.sv
// recv_all: reassembles six link words from the peer board into one
// game-control message for GameControl.
// Ports:
//   clk, rst, interboard_rst   clock; either reset (sync, active high) clears all
//   Request_in, inter_data_in  four-phase link input from the peer board
//   Ack_out                    link acknowledge to the peer board
//   ctrl_valid                 one-cycle pulse: ctrl_* hold a new message
//   ctrl_msg_type .. ctrl_move_dir  message fields, held until the next message
//   rx_busy                    a message is partially received
//   rx_error                   one-cycle pulse on inter-word timeout abort
// Optional feature: define RECV_TIMEOUT_EN to abort a partial message after
// TIMEOUT_CYCLES idle cycles between words; otherwise rx_error is tied low.
module recv_all
    import recv_all_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       ctrl_valid,
    output logic [3:0] ctrl_msg_type,
    output logic [4:0] ctrl_block_x,
    output logic [2:0] ctrl_block_y,
    output logic [5:0] ctrl_card,
    output logic [2:0] ctrl_sel_len,
    output logic [0:0] ctrl_move_dir,
    output logic       rx_busy,
    output logic       rx_error
);

    logic                  rst_all_s;
    logic [WORD_W-1:0]     word_s;
    logic                  word_done_s;
    logic [2:0]            idx_r;
    logic [2:0]            idx_inc_s;
    logic [MSG_TYPE_W-1:0] f_msg_type_r;
    logic [BLOCK_X_W-1:0]  f_block_x_r;
    logic [BLOCK_Y_W-1:0]  f_block_y_r;
    logic [CARD_W-1:0]     f_card_r;
    logic [SEL_LEN_W-1:0]  f_sel_len_r;

    assign rst_all_s = rst | interboard_rst;
    assign idx_inc_s = next_word_idx(idx_r);

    recv_single u_single (
        .clk       (clk),
        .rst       (rst_all_s),
        .req_in    (Request_in),
        .data_in   (inter_data_in),
        .ack       (Ack_out),
        .word      (word_s),
        .word_done (word_done_s)
    );

`ifdef RECV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             rx_idle_s;

    // recv_single sits in WAIT_REQ_UP exactly when it is neither acking nor finishing.
    assign rx_idle_s = ~Ack_out & ~word_done_s;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign rx_error = 1'b0;
`endif

    // Word index, field registers, output registers and inter-word timeout.
    always_ff @(posedge clk) begin
        if (rst_all_s) begin
            idx_r         <= IDX_MSG_TYPE;
            f_msg_type_r  <= {MSG_TYPE_W{1'b0}};
            f_block_x_r   <= {BLOCK_X_W{1'b0}};
            f_block_y_r   <= {BLOCK_Y_W{1'b0}};
            f_card_r      <= {CARD_W{1'b0}};
            f_sel_len_r   <= {SEL_LEN_W{1'b0}};
            ctrl_valid    <= 1'b0;
            ctrl_msg_type <= 4'd0;
            ctrl_block_x  <= 5'd0;
            ctrl_block_y  <= 3'd0;
            ctrl_card     <= 6'd0;
            ctrl_sel_len  <= 3'd0;
            ctrl_move_dir <= 1'b0;
            rx_busy       <= 1'b0;
`ifdef RECV_TIMEOUT_EN
            tmo_cnt_r     <= {CNT_W{1'b0}};
            rx_error      <= 1'b0;
`endif
        end else begin
            ctrl_valid <= 1'b0;
`ifdef RECV_TIMEOUT_EN
            rx_error   <= 1'b0;
`endif
            if (word_done_s) begin
                // A completed word always wins over a simultaneous timeout.
                idx_r   <= idx_inc_s;
                rx_busy <= (idx_inc_s != IDX_MSG_TYPE);
`ifdef RECV_TIMEOUT_EN
                tmo_cnt_r <= {CNT_W{1'b0}};
`endif
                case (idx_r)
                    IDX_MSG_TYPE: f_msg_type_r <= word_s[MSG_TYPE_W-1:0];
                    IDX_BLOCK_X:  f_block_x_r  <= word_s[BLOCK_X_W-1:0];
                    IDX_BLOCK_Y:  f_block_y_r  <= word_s[BLOCK_Y_W-1:0];
                    IDX_CARD:     f_card_r     <= word_s[CARD_W-1:0];
                    IDX_SEL_LEN:  f_sel_len_r  <= word_s[SEL_LEN_W-1:0];
                    IDX_MOVE_DIR: begin
                        // Last word goes straight to the outputs with the rest.
                        ctrl_msg_type <= f_msg_type_r;
                        ctrl_block_x  <= f_block_x_r;
                        ctrl_block_y  <= f_block_y_r;
                        ctrl_card     <= f_card_r;
                        ctrl_sel_len  <= f_sel_len_r;
                        ctrl_move_dir <= word_s[MOVE_DIR_W-1:0];
                        ctrl_valid    <= 1'b1;
                    end
                    default: begin
                        // Unreachable index: restart the message.
                        idx_r   <= IDX_MSG_TYPE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
`ifdef RECV_TIMEOUT_EN
            else if ((idx_r != IDX_MSG_TYPE) && rx_idle_s) begin
                if (tmo_cnt_r == CNT_LIMIT) begin
                    idx_r     <= IDX_MSG_TYPE;
                    rx_busy   <= 1'b0;
                    tmo_cnt_r <= {CNT_W{1'b0}};
                    rx_error  <= 1'b1;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_recv_all.sv
// Bench for recv_all: a peer-board sender drives four-phase handshakes with
// random asynchronous offsets; a message-level model predicts ctrl_*, rx_busy
// and rx_error, compared every cycle on the falling clock edge.
module tb_recv_all;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        interboard_rst;
    logic        Request_in;
    logic [5:0]  inter_data_in;
    logic        Ack_out;
    logic        ctrl_valid;
    logic [3:0]  ctrl_msg_type;
    logic [4:0]  ctrl_block_x;
    logic [2:0]  ctrl_block_y;
    logic [5:0]  ctrl_card;
    logic [2:0]  ctrl_sel_len;
    logic [0:0]  ctrl_move_dir;
    logic        rx_busy;
    logic        rx_error;
    logic [21:0] dut_pack;

    recv_all #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .Request_in     (Request_in),
        .inter_data_in  (inter_data_in),
        .Ack_out        (Ack_out),
        .ctrl_valid     (ctrl_valid),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_block_x   (ctrl_block_x),
        .ctrl_block_y   (ctrl_block_y),
        .ctrl_card      (ctrl_card),
        .ctrl_sel_len   (ctrl_sel_len),
        .ctrl_move_dir  (ctrl_move_dir),
        .rx_busy        (rx_busy),
        .rx_error       (rx_error)
    );

    always #5 clk = ~clk;

    assign dut_pack = {ctrl_msg_type, ctrl_block_x, ctrl_block_y,
                       ctrl_card, ctrl_sel_len, ctrl_move_dir};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_rises = 0;
    int valid_cnt = 0;
    bit checking = 1'b0;

    // message-level model
    int m_idx = 0;
    int m_words[6];
    int e_fields = 0;
    int e_valid;
    int e_err;
    bit pend = 1'b0;
    int pend_at = 0;
    int pend_word = 0;
    int err_at = -1;
    int last_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_idx    = 0;
        e_fields = 0;
        pend     = 1'b0;
        err_at   = -1;
    endtask

    initial forever begin
        @(posedge Ack_out);
        ack_rises++;
    end

    // Per-cycle comparison against the message model.
    initial forever begin
        @(negedge clk);
        cyc++;
        e_valid = 0;
        e_err   = 0;
        if (pend && cyc == pend_at) begin
            pend = 1'b0;
            m_words[m_idx] = pend_word;
            if (m_idx == 5) begin
                m_idx = 0;
                e_valid = 1;
                e_fields = m_words[0] % 16;
                e_fields = e_fields * 32 + m_words[1] % 32;
                e_fields = e_fields * 8  + m_words[2] % 8;
                e_fields = e_fields * 64 + m_words[3] % 64;
                e_fields = e_fields * 8  + m_words[4] % 8;
                e_fields = e_fields * 2  + m_words[5] % 2;
            end else begin
                m_idx++;
            end
        end
        if (cyc == err_at) begin
            e_err = 1;
            m_idx = 0;
        end
        if (checking && !rst && !interboard_rst) begin
            check("ctrl_valid", 32'(ctrl_valid), 32'(e_valid));
            check("ctrl_fields", 32'(dut_pack), 32'(e_fields));
            check("rx_busy", 32'(rx_busy), 32'(m_idx != 0));
            check("rx_error", 32'(rx_error), 32'(e_err));
            if (ctrl_valid === 1'b1) valid_cnt++;
        end
    end

    task automatic raise_req(input logic [5:0] w);
        int n;
        @(posedge clk);
        #1;
        inter_data_in = w;
        #($urandom_range(0, 7));
        Request_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (Ack_out !== 1'b1 && n < 20);
        check("ack_rise_edges", 32'(n), 32'd3);
    endtask

    task automatic drop_req(input logic [5:0] w);
        int n;
        #($urandom_range(0, 7));
        Request_in = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (Ack_out !== 1'b0 && n < 20);
        check("ack_fall_edges", 32'(n), 32'd3);
        // word_done is this cycle; index/outputs move on the next edge
        pend_word     = int'(w);
        pend_at       = cyc + 2;
        pend          = 1'b1;
        last_done_cyc = cyc;
    endtask

    task automatic send_word(input logic [5:0] w);
        raise_req(w);
        drop_req(w);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_msg(input logic [35:0] m);
        for (int i = 0; i < 6; i++) begin
            send_word(m[i*6 +: 6]);
        end
    endtask

    function automatic logic [35:0] rand_msg();
        return {4'($urandom()), $urandom()};
    endfunction

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] m;
        int v0;
        int a0;

        rst = 1'b1;
        interboard_rst = 1'b0;
        Request_in = 1'b0;
        inter_data_in = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_ack", 32'(Ack_out), 32'd0);
        check("rst_valid", 32'(ctrl_valid), 32'd0);
        check("rst_fields", 32'(dut_pack), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_err", 32'(rx_error), 32'd0);
        rst = 1'b0;
        model_reset();
        checking = 1'b1;

        // known message
        v0 = valid_cnt;
        a0 = ack_rises;
        send_msg({6'd1, 6'd3, 6'd42, 6'd5, 6'd17, 6'h0A});
        settle();
        check("msgA_type", 32'(ctrl_msg_type), 32'hA);
        check("msgA_block_x", 32'(ctrl_block_x), 32'd17);
        check("msgA_block_y", 32'(ctrl_block_y), 32'd5);
        check("msgA_card", 32'(ctrl_card), 32'd42);
        check("msgA_sel_len", 32'(ctrl_sel_len), 32'd3);
        check("msgA_move_dir", 32'(ctrl_move_dir), 32'd1);
        check("msgA_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("msgA_ack_rises", 32'(ack_rises - a0), 32'd6);

        // upper bits of a narrow field are dropped
        m = rand_msg();
        m[17:12] = 6'b111101;
        send_msg(m);
        settle();
        check("trunc_block_y", 32'(ctrl_block_y), 32'd5);

        // two back-to-back messages
        v0 = valid_cnt;
        send_msg(rand_msg());
        send_msg(rand_msg());
        settle();
        check("b2b_valid_pulses", 32'(valid_cnt - v0), 32'd2);

        // rst while Ack_out is high during word 3
        m = rand_msg();
        for (int i = 0; i < 3; i++) send_word(m[i*6 +: 6]);
        raise_req(m[23:18]);
        rst = 1'b1;
        Request_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_mid_ack", 32'(Ack_out), 32'd0);
        check("rst_mid_busy", 32'(rx_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        v0 = valid_cnt;
        send_msg(rand_msg());
        settle();
        check("after_rst_valid_pulses", 32'(valid_cnt - v0), 32'd1);

        // interboard_rst during word 1
        m = rand_msg();
        send_word(m[5:0]);
        raise_req(m[11:6]);
        interboard_rst = 1'b1;
        Request_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("ibrst_ack", 32'(Ack_out), 32'd0);
        check("ibrst_busy", 32'(rx_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        interboard_rst = 1'b0;
        send_msg(rand_msg());
        settle();

`ifdef RECV_TIMEOUT_EN
        // stall after two words: abort TO+3 model cycles after the last word_done
        m = rand_msg();
        send_word(m[5:0]);
        send_word(m[11:6]);
        err_at = last_done_cyc + TO + 3;
        while (cyc <= err_at + 1) @(posedge clk);
        #1;
        check("tmo_busy", 32'(rx_busy), 32'd0);
        v0 = valid_cnt;
        send_msg(rand_msg());
        settle();
        check("tmo_next_valid", 32'(valid_cnt - v0), 32'd1);
`endif

        // random traffic
        for (int k = 0; k < 8; k++) begin
            send_msg(rand_msg());
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
